// File: rtl/mode_arb_pkg.sv
// rtl/mode_arb_pkg.sv - shared state/mode types and default thresholds for the mode arbiter
package mode_arb_pkg;

  typedef enum logic [2:0] {
    SCALAR = 3'd0,
    ARM    = 3'd1,
    DRAIN  = 3'd2,
    SWITCH = 3'd3,
    ACCEL  = 3'd4
  } arb_state_t;

  typedef enum logic {
    MODE_SCALAR = 1'b0,
    MODE_ACCEL  = 1'b1
  } mode_t;

  localparam int unsigned DEF_CONF_ENTER  = 20;
  localparam int unsigned DEF_CONF_EXIT   = 12;
  localparam int unsigned DEF_MIN_RUNLEN  = 8;
  localparam int unsigned DEF_CONFIRM     = 4;
  localparam int unsigned DEF_MIN_DWELL   = 16;
  localparam int unsigned DEF_ACK_TIMEOUT = 32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mode_arbiter.sv
// rtl/mode_arbiter.sv - scalar/accel mode arbiter with hysteresis, dwell, confirmation
// and a stall/drain/ack sequenced switch toward the execute-stage mode mux
module mode_arbiter
  import mode_arb_pkg::*;
#(
  parameter int unsigned CONF_ENTER  = DEF_CONF_ENTER,
  parameter int unsigned CONF_EXIT   = DEF_CONF_EXIT,
  parameter int unsigned MIN_RUNLEN  = DEF_MIN_RUNLEN,
  parameter int unsigned CONFIRM     = DEF_CONFIRM,
  parameter int unsigned MIN_DWELL   = DEF_MIN_DWELL,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wa_req,
  input  logic [7:0]  confidence,
  input  logic [7:0]  predicted_runlen,
  input  logic        pipe_idle,
  input  logic        mode_ack,
  input  logic        force_scalar,
  output logic        mode_sel,
  output logic        stall_fetch,
  output logic        switch_req,
  output logic        target_mode,
  output logic        switch_fail,
  output logic [2:0]  arb_state,
  output logic [15:0] switch_count
);

  localparam logic [7:0] CONF_ENTER_C  = 8'(CONF_ENTER);
  localparam logic [7:0] CONF_EXIT_C   = 8'(CONF_EXIT);
  localparam logic [7:0] MIN_RUNLEN_C  = 8'(MIN_RUNLEN);
  localparam logic [7:0] CONFIRM_C     = 8'(CONFIRM);
  localparam logic [7:0] MIN_DWELL_C   = 8'(MIN_DWELL);
  localparam logic [7:0] ACK_TIMEOUT_C = 8'(ACK_TIMEOUT);

  arb_state_t  state_q, state_d;
  mode_t       mode_q, mode_d;
  mode_t       target_q, target_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        phase_q, phase_d;
  logic [7:0]  arm_q, arm_d;
  logic [7:0]  ack_q, ack_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stall_q, stall_d;
  logic        req_q, req_d;
  logic        fail_q, fail_d;

  logic        enter_ok;
  logic        dwell_ok;
  logic        to_accel;
  logic [7:0]  arm_inc;
  logic [7:0]  ack_inc;
  arb_state_t  src_state;

  assign enter_ok  = wa_req && (confidence >= CONF_ENTER_C) && (predicted_runlen >= MIN_RUNLEN_C);
  assign dwell_ok  = (dwell_q >= MIN_DWELL_C);
  assign to_accel  = (target_q == MODE_ACCEL);
  assign arm_inc   = arm_q + 8'd1;
  assign ack_inc   = ack_q + 8'd1;
  assign src_state = (mode_q == MODE_ACCEL) ? ACCEL : SCALAR;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    arm_d    = arm_q;
    ack_d    = 8'd0;
    cnt_d    = cnt_q;
    fail_d   = 1'b0;

    case (state_q)
      SCALAR: begin
        arm_d = 8'd0;
        if (!force_scalar && enter_ok && dwell_ok) begin
          state_d = ARM;
          arm_d   = 8'd1;
        end
      end

      ARM: begin
        if (force_scalar || !enter_ok) begin
          state_d = SCALAR;
          arm_d   = 8'd0;
        end else if (arm_inc >= CONFIRM_C) begin
          state_d  = DRAIN;
          target_d = MODE_ACCEL;
          arm_d    = 8'd0;
        end else begin
          arm_d = arm_inc;
        end
      end

      // An exit toward scalar is already where force wants to go, so it carries on.
      DRAIN: begin
        if (force_scalar && to_accel) begin
          state_d = SCALAR;
        end else if (pipe_idle) begin
          state_d = SWITCH;
        end
      end

      SWITCH: begin
        if (force_scalar && to_accel) begin
          state_d = SCALAR;
        end else if (mode_ack) begin
          mode_d  = target_q;
          cnt_d   = sat_inc16(cnt_q);
          state_d = to_accel ? ACCEL : SCALAR;
        end else if (ack_inc >= ACK_TIMEOUT_C) begin
          state_d = src_state;
          fail_d  = 1'b1;
        end else begin
          ack_d = ack_inc;
        end
      end

      ACCEL: begin
        if (force_scalar || (dwell_ok && (confidence < CONF_EXIT_C))) begin
          state_d  = DRAIN;
          target_d = MODE_SCALAR;
        end
      end

      default: begin
        state_d = SCALAR;
      end
    endcase

    stall_d = (state_d == DRAIN) || (state_d == SWITCH);
    req_d   = (state_d == SWITCH);
  end

  // Dwell advances on every second cycle and restarts whenever the mode flips.
  always_comb begin
    phase_d = ~phase_q;
    dwell_d = dwell_q;
    if (mode_d != mode_q) begin
      phase_d = 1'b0;
      dwell_d = 8'd0;
    end else if (phase_q && (dwell_q != 8'hFF)) begin
      dwell_d = dwell_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCALAR;
      mode_q   <= MODE_SCALAR;
      target_q <= MODE_SCALAR;
      dwell_q  <= 8'd0;
      phase_q  <= 1'b0;
      arm_q    <= 8'd0;
      ack_q    <= 8'd0;
      cnt_q    <= 16'd0;
      stall_q  <= 1'b0;
      req_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      phase_q  <= phase_d;
      arm_q    <= arm_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      req_q    <= req_d;
      fail_q   <= fail_d;
    end
  end

  logic [15:0] switch_count_q;
  assign switch_count_q = cnt_q;

  assign mode_sel     = mode_q;
  assign stall_fetch  = stall_q;
  assign switch_req   = req_q;
  assign target_mode  = target_q;
  assign switch_fail  = fail_q;
  assign arb_state    = state_q;
  assign switch_count = switch_count_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// tb/tb_mode_arbiter.sv - directed self-checking bench for mode_arbiter
module tb_mode_arbiter;
  import mode_arb_pkg::*;

  localparam int CONFIRM_T   = 4;
  localparam int MIN_DWELL_T = 16;
  localparam int ACK_TO_T    = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wa_req = 1'b0;
  logic [7:0]  confidence = 8'd0;
  logic [7:0]  predicted_runlen = 8'd0;
  logic        pipe_idle = 1'b0;
  logic        mode_ack = 1'b0;
  logic        force_scalar = 1'b0;
  logic        mode_sel;
  logic        stall_fetch;
  logic        switch_req;
  logic        target_mode;
  logic        switch_fail;
  logic [2:0]  arb_state;
  logic [15:0] switch_count;

  int checks = 0;
  int errors = 0;

  mode_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wa_req(wa_req), .confidence(confidence),
    .predicted_runlen(predicted_runlen), .pipe_idle(pipe_idle), .mode_ack(mode_ack),
    .force_scalar(force_scalar), .mode_sel(mode_sel), .stall_fetch(stall_fetch),
    .switch_req(switch_req), .target_mode(target_mode), .switch_fail(switch_fail),
    .arb_state(arb_state), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [7:0] conf, input logic [7:0] rl,
                       input logic idle, input logic ack, input logic frc);
    wa_req = req; confidence = conf; predicted_runlen = rl;
    pipe_idle = idle; mode_ack = ack; force_scalar = frc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (arb_state !== s && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'd30, 8'd10, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", arb_state); end
    checks++; if (mode_sel !== 1'b0) begin errors++; $display("FAIL reset_mode got %0b exp 0", mode_sel); end
    checks++; if (stall_fetch !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_fetch); end
    checks++; if (switch_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", switch_req); end
    checks++; if (target_mode !== 1'b0) begin errors++; $display("FAIL reset_target got %0b exp 0", target_mode); end
    checks++; if (switch_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %0b exp 0", switch_fail); end
    checks++; if (switch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", switch_count); end
  endtask

  task automatic test_entry();
    int arm_e, drain_e, sw_e, mode_e;
    logic req_at_sw, tgt_at_sw, early_stall;
    do_reset();
    drive(1'b1, 8'd30, 8'd10, 1'b1, 1'b1, 1'b0);
    arm_e = 0; drain_e = 0; sw_e = 0; mode_e = 0;
    req_at_sw = 1'b0; tgt_at_sw = 1'b0; early_stall = 1'b0;
    for (int e = 1; e <= 80 && mode_e == 0; e++) begin
      tick();
      if (arm_e == 0 && stall_fetch === 1'b1) early_stall = 1'b1;
      if (arm_e == 0 && arb_state === ARM) arm_e = e;
      if (drain_e == 0 && arb_state === DRAIN) drain_e = e;
      if (sw_e == 0 && arb_state === SWITCH) begin
        sw_e = e; req_at_sw = switch_req; tgt_at_sw = target_mode;
      end
      if (mode_sel === 1'b1) mode_e = e;
    end
    checks++; if (arm_e != 2*MIN_DWELL_T+1) begin errors++; $display("FAIL entry_arm_cycle got %0d exp %0d", arm_e, 2*MIN_DWELL_T+1); end
    checks++; if (early_stall !== 1'b0) begin errors++; $display("FAIL entry_early_stall got 1 exp 0"); end
    checks++; if (drain_e != arm_e+CONFIRM_T-1) begin errors++; $display("FAIL entry_drain_cycle got %0d exp %0d", drain_e, arm_e+CONFIRM_T-1); end
    checks++; if (req_at_sw !== 1'b1 || tgt_at_sw !== 1'b1) begin errors++; $display("FAIL entry_switch_outputs got req=%0b tgt=%0b exp 1 1", req_at_sw, tgt_at_sw); end
    checks++; if (mode_e != arm_e-1+CONFIRM_T+2) begin errors++; $display("FAIL entry_latency got %0d exp %0d", mode_e, arm_e-1+CONFIRM_T+2); end
    checks++; if (switch_count !== 16'd1) begin errors++; $display("FAIL entry_count got %0d exp 1", switch_count); end
    checks++; if (arb_state !== ACCEL || stall_fetch !== 1'b0 || switch_req !== 1'b0) begin errors++; $display("FAIL entry_final got st=%0d stall=%0b req=%0b exp 4 0 0", arb_state, stall_fetch, switch_req); end
  endtask

  task automatic test_arm_abort();
    do_reset();
    drive(1'b1, 8'd30, 8'd10, 1'b0, 1'b0, 1'b0);
    wait_state(ARM, 60);
    checks++; if (arb_state !== ARM) begin errors++; $display("FAIL abort_reach_arm got %0d exp 1", arb_state); end
    tick();
    checks++; if (arb_state !== ARM) begin errors++; $display("FAIL abort_arm2 got %0d exp 1", arb_state); end
    confidence = 8'd15;
    tick();
    checks++; if (arb_state !== SCALAR || stall_fetch !== 1'b0 || mode_sel !== 1'b0) begin errors++; $display("FAIL abort_back_scalar got st=%0d stall=%0b mode=%0b exp 0 0 0", arb_state, stall_fetch, mode_sel); end
  endtask

  task automatic test_accel_exit();
    logic left;
    do_reset();
    drive(1'b1, 8'd30, 8'd10, 1'b1, 1'b1, 1'b0);
    wait_state(ACCEL, 80);
    checks++; if (mode_sel !== 1'b1) begin errors++; $display("FAIL exit_enter_accel got %0b exp 1", mode_sel); end
    drive(1'b1, 8'd15, 8'd10, 1'b0, 1'b0, 1'b0);
    left = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (arb_state !== ACCEL) left = 1'b1;
    end
    checks++; if (left !== 1'b0) begin errors++; $display("FAIL exit_hysteresis got left=1 exp 0"); end
    confidence = 8'd11;
    tick();
    checks++; if (arb_state !== DRAIN || target_mode !== 1'b0 || stall_fetch !== 1'b1) begin errors++; $display("FAIL exit_drain got st=%0d tgt=%0b stall=%0b exp 2 0 1", arb_state, target_mode, stall_fetch); end
    left = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (arb_state !== DRAIN || stall_fetch !== 1'b1) left = 1'b1;
    end
    checks++; if (left !== 1'b0) begin errors++; $display("FAIL exit_drain_hold got left=1 exp 0"); end
    pipe_idle = 1'b1;
    tick();
    checks++; if (arb_state !== SWITCH || switch_req !== 1'b1) begin errors++; $display("FAIL exit_switch got st=%0d req=%0b exp 3 1", arb_state, switch_req); end
    mode_ack = 1'b1;
    tick();
    checks++; if (mode_sel !== 1'b0 || arb_state !== SCALAR || switch_count !== 16'd2 || stall_fetch !== 1'b0) begin errors++; $display("FAIL exit_done got mode=%0b st=%0d cnt=%0d stall=%0b exp 0 0 2 0", mode_sel, arb_state, switch_count, stall_fetch); end
  endtask

  task automatic test_ack_timeout();
    logic early;
    do_reset();
    drive(1'b1, 8'd30, 8'd10, 1'b1, 1'b0, 1'b0);
    wait_state(SWITCH, 80);
    wa_req = 1'b0;
    early = 1'b0;
    for (int i = 1; i < ACK_TO_T; i++) begin
      tick();
      if (arb_state !== SWITCH || switch_fail !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL timeout_early got left=1 exp 0"); end
    tick();
    checks++; if (switch_fail !== 1'b1 || arb_state !== SCALAR || mode_sel !== 1'b0 || switch_req !== 1'b0) begin errors++; $display("FAIL timeout_abort got fail=%0b st=%0d mode=%0b req=%0b exp 1 0 0 0", switch_fail, arb_state, mode_sel, switch_req); end
    checks++; if (switch_count !== 16'd0) begin errors++; $display("FAIL timeout_count got %0d exp 0", switch_count); end
    tick();
    checks++; if (switch_fail !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %0b exp 0", switch_fail); end
  endtask

  task automatic test_force();
    do_reset();
    drive(1'b1, 8'd30, 8'd10, 1'b0, 1'b0, 1'b0);
    wait_state(DRAIN, 80);
    checks++; if (target_mode !== 1'b1) begin errors++; $display("FAIL force_drain_target got %0b exp 1", target_mode); end
    force_scalar = 1'b1;
    tick();
    checks++; if (arb_state !== SCALAR || stall_fetch !== 1'b0 || switch_req !== 1'b0) begin errors++; $display("FAIL force_drain_cancel got st=%0d stall=%0b req=%0b exp 0 0 0", arb_state, stall_fetch, switch_req); end
    tick();
    checks++; if (arb_state !== SCALAR) begin errors++; $display("FAIL force_blocks_arm got %0d exp 0", arb_state); end
    force_scalar = 1'b0; pipe_idle = 1'b1;
    wait_state(SWITCH, 20);
    mode_ack = 1'b1; force_scalar = 1'b1;
    tick();
    checks++; if (arb_state !== SCALAR || mode_sel !== 1'b0 || switch_count !== 16'd0) begin errors++; $display("FAIL force_vs_ack got st=%0d mode=%0b cnt=%0d exp 0 0 0", arb_state, mode_sel, switch_count); end

    do_reset();
    drive(1'b1, 8'd30, 8'd10, 1'b1, 1'b1, 1'b0);
    wait_state(ACCEL, 80);
    drive(1'b0, 8'd30, 8'd10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    force_scalar = 1'b1;
    tick();
    checks++; if (arb_state !== DRAIN || target_mode !== 1'b0 || stall_fetch !== 1'b1) begin errors++; $display("FAIL force_accel_drain got st=%0d tgt=%0b stall=%0b exp 2 0 1", arb_state, target_mode, stall_fetch); end
    tick();
    checks++; if (arb_state !== DRAIN) begin errors++; $display("FAIL force_exit_continues got %0d exp 2", arb_state); end
    pipe_idle = 1'b1;
    tick();
    mode_ack = 1'b1;
    tick();
    checks++; if (arb_state !== SCALAR || mode_sel !== 1'b0 || switch_count !== 16'd2) begin errors++; $display("FAIL force_exit_done got st=%0d mode=%0b cnt=%0d exp 0 0 2", arb_state, mode_sel, switch_count); end
    drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    checks++; if (switch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_preload got %0h exp ffff", switch_count); end
    drive(1'b1, 8'd30, 8'd10, 1'b1, 1'b1, 1'b0);
    wait_state(ACCEL, 80);
    checks++; if (mode_sel !== 1'b1 || switch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got mode=%0b cnt=%0h exp 1 ffff", mode_sel, switch_count); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 8'd11, 8'd0, 1'b1, 1'b0, 1'b0);
    wait_state(SWITCH, 80);
    checks++; if (switch_req !== 1'b1 || mode_sel !== 1'b1) begin errors++; $display("FAIL areset_pre got req=%0b mode=%0b exp 1 1", switch_req, mode_sel); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (arb_state !== 3'd0 || mode_sel !== 1'b0 || stall_fetch !== 1'b0 || switch_req !== 1'b0) begin errors++; $display("FAIL areset_ctrl got st=%0d mode=%0b stall=%0b req=%0b exp 0 0 0 0", arb_state, mode_sel, stall_fetch, switch_req); end
    checks++; if (target_mode !== 1'b0 || switch_fail !== 1'b0 || switch_count !== 16'd0) begin errors++; $display("FAIL areset_misc got tgt=%0b fail=%0b cnt=%0h exp 0 0 0", target_mode, switch_fail, switch_count); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_entry();
    test_arm_abort();
    test_accel_exit();
    test_ack_timeout();
    test_force();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
